dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the MEM stage of the pipelined MIPS core.
- Replaces the single-cycle data memory with a valid/ready request interface and a fixed-latency response.
- Asserts a stall toward the hazard logic while an access is in flight.
- Holds a word-addressed RAM and flags misaligned or out-of-range accesses.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; legal word index is 0..DEPTH_WORDS-1.
- LATENCY, 3: cycles from request accept to response; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- req_valid  in  1  MEM-stage access request
- req_write  in  1  1 = store (sw), 0 = load (lw)
- req_addr  in  32  byte address (ALUOutM)
- req_wdata  in  32  store data (WriteDataM)
- req_ready  out  1  responder can accept a request this cycle
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  load data; valid only with resp_valid
- resp_err  out  1  with resp_valid: misaligned or out-of-range access
- stall  out  1  hold the pipeline (to hazard unit)

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - RAM contents are not cleared.
  - Reset overrides all other events on the same edge.
- Registered state: IDLE, WAIT, RESP; 4-bit down-counter cnt; latched addr, wdata, write and err.
- Accept:
  - A request is accepted in cycle N when req_valid=1 and req_ready=1.
  - req_ready = (state==IDLE), combinational from state only.
  - On the accept edge: latch addr, wdata and write; compute err = (addr[1:0]!=0) or (addr[31:2] >= DEPTH_WORDS); load cnt = LATENCY-1.
- Transitions:
  - IDLE -> RESP if accepting and LATENCY==1.
  - IDLE -> WAIT if accepting and LATENCY>1.
  - IDLE -> IDLE otherwise.
  - WAIT -> RESP when cnt==1; otherwise cnt decrements and stays in WAIT.
  - RESP -> IDLE unconditionally.
- Commit:
  - On the edge that enters RESP: if write and not err, write RAM[addr[31:2]] = wdata.
  - On the same edge: resp_rdata = (not write and not err) ? RAM[addr[31:2]] : 0; resp_err = err.
  - A read sees the RAM content from before that same edge. No read/write collision is possible, since only one access is in flight.
- Response timing:
  - resp_valid=1 exactly in cycle N+LATENCY (state RESP), for one cycle.
  - resp_rdata and resp_err hold their values until the next RESP entry.
- Throughput: IDLE follows RESP, so the next accept is at the earliest in cycle N+LATENCY+1. Maximum rate is one access per LATENCY+1 cycles.
- Stall:
  - stall = (req_valid and state==IDLE) or (state==WAIT). Combinational.
  - stall is 0 in RESP, so the pipeline advances on the response edge and the load result enters MEM/WB.
- Errored access: same latency, no RAM write, rdata=0, resp_err=1. The core treats it as a completed access; trap handling is outside this block.
- Ignored inputs:
  - req_* are ignored while state != IDLE; no queueing.
  - req_valid dropped in WAIT does not cancel the access.
- Reset mid-operation:
  - The in-flight access is discarded and no resp_valid is produced.
  - A store is written only if its commit edge preceded the reset edge.
- Address wrap: none. Indices at or above DEPTH_WORDS are errors, never aliased.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then release. Required: req_ready=1, resp_valid=0, stall=0, resp_rdata=0 every cycle with req_valid=0.
- Store/load, LATENCY=3:
  - sw addr=0x10, wdata=0xDEADBEEF accepted in cycle 5. Required: stall=1 in cycles 5-7; resp_valid=1, resp_err=0 in cycle 8; req_ready=1 again in cycle 9.
  - lw addr=0x10 accepted in cycle 9. Required: resp_valid=1 in cycle 12 with resp_rdata=0xDEADBEEF.
- LATENCY=1 back-to-back:
  - sw 0x4 <- 0x12345678 in cycle N. Required: resp_valid=1 in N+1, req_ready=0 in N+1.
  - lw 0x4 accepted in N+2. Required: resp_valid=1 in N+3 with rdata=0x12345678.
- Error cases, LATENCY=3:
  - sw addr=0x13 (misaligned). Required: resp_err=1 at +3 cycles.
  - lw addr=0x400 (index 256, DEPTH_WORDS=256). Required: resp_err=1, rdata=0.
  - A following lw 0x10 must still return its prior value, showing no corruption.
- Reset mid-operation:
  - Accept sw 0x20 <- 0xAAAA5555, assert reset=0 one cycle after the accept. Required: no resp_valid, state IDLE.
  - A later lw 0x20 returns the pre-test content, not 0xAAAA5555.
- Ignored request in WAIT: change req_addr/req_write while in WAIT. Required: the response reflects the originally accepted request and exactly one resp_valid pulse occurs.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage of the pipelined MIPS core.
// Accepts one load/store at a time over a valid/ready handshake, answers after a
// fixed LATENCY with a one-cycle resp_valid pulse, and holds the pipeline via
// stall while the access is in flight. Misaligned or out-of-range word indices
// complete normally but with resp_err set, no RAM write and zero read data.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    // Width of a legal word index; out-of-range indices never reach the RAM.
    localparam int IdxWidth = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT                state;
    stateT                nextState;
    logic [3:0]           cnt;
    logic [3:0]           nextCnt;

    // Request fields captured on the accept edge.
    logic [IdxWidth-1:0]  idxQ;
    logic [31:0]          wdataQ;
    logic                 writeQ;
    logic                 errQ;

    // Access being committed on the edge that enters RESP.
    logic                 accept;
    logic                 reqErr;
    logic [IdxWidth-1:0]  reqIdx;
    logic [IdxWidth-1:0]  commitIdx;
    logic [31:0]          commitWdata;
    logic                 commitWrite;
    logic                 commitErr;
    logic                 enterResp;

    logic [31:0]          mem [DEPTH_WORDS];
    logic [31:0]          rdataQ;
    logic                 respErrQ;

    assign accept    = req_valid && (state == IDLE);
    assign reqErr    = (req_addr[1:0] != 2'b00) ||
                       ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign reqIdx    = req_addr[IdxWidth+1:2];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign stall      = (req_valid && (state == IDLE)) || (state == WAIT);
    assign resp_rdata = rdataQ;
    assign resp_err   = respErrQ;

    // Next-state and counter logic for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        nextState = state;
        nextCnt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nextCnt   = 4'(LATENCY - 1);
                    nextState = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    nextState = RESP;
                end else begin
                    nextCnt = cnt - 4'd1;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Select the committing access: live request when LATENCY==1 lets IDLE
    // jump straight to RESP, otherwise the fields latched at accept time.
    always_comb begin
        commitIdx   = idxQ;
        commitWdata = wdataQ;
        commitWrite = writeQ;
        commitErr   = errQ;
        if (state == IDLE) begin
            commitIdx   = reqIdx;
            commitWdata = req_wdata;
            commitWrite = req_write;
            commitErr   = reqErr;
        end
        enterResp = reset && (nextState == RESP) && (state != RESP);
    end

    // State register, counter and request capture; reset discards any access.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            idxQ   <= '0;
            wdataQ <= 32'd0;
            writeQ <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (accept) begin
                idxQ   <= reqIdx;
                wdataQ <= req_wdata;
                writeQ <= req_write;
                errQ   <= reqErr;
            end
        end
    end

    // Response data and error flag, updated only on RESP entry and held after.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdataQ   <= 32'd0;
            respErrQ <= 1'b0;
        end else if (enterResp) begin
            rdataQ   <= (!commitWrite && !commitErr) ? mem[commitIdx] : 32'd0;
            respErrQ <= commitErr;
        end
    end

    // Word RAM write port; a store lands on the same edge that enters RESP.
    always_ff @(posedge clk) begin
        // NOTE: the RAM has no reset so it maps onto block memory and survives reset.
        if (enterResp && commitWrite && !commitErr) begin
            mem[commitIdx] <= commitWdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=3, one at LATENCY=1.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic        rv3, rw3, ready3, respValid3, err3, stall3;
    logic [31:0] ra3, rd3, rdata3;
    logic        rv1, rw1, ready1, respValid1, err1, stall1;
    logic [31:0] ra1, rd1, rdata1;

    int nChecks;
    int nFails;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u3 (
        .clk(clk), .reset(reset),
        .req_valid(rv3), .req_write(rw3), .req_addr(ra3), .req_wdata(rd3),
        .req_ready(ready3), .resp_valid(respValid3), .resp_rdata(rdata3),
        .resp_err(err3), .stall(stall3)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(rv1), .req_write(rw1), .req_addr(ra1), .req_wdata(rd1),
        .req_ready(ready1), .resp_valid(respValid1), .resp_rdata(rdata1),
        .resp_err(err1), .stall(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // One access on the LATENCY=3 instance: latency, stall profile, data, error, pulse width.
    task automatic acc3(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] expData, input logic expErr);
        int lat;
        int nStall;
        logic [31:0] gotData;
        logic gotErr;
        lat = 0;
        nStall = 0;
        gotData = 32'hxxxx_xxxx;
        gotErr = 1'bx;
        cyc();
        rv3 = 1'b1; rw3 = w; ra3 = a; rd3 = d;
        #1;
        check({tag, " ready"}, 32'(ready3), 32'd1);
        check({tag, " stallAcc"}, 32'(stall3), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            rv3 = 1'b0;
            #1;
            if (respValid3) begin
                lat = i;
                gotData = rdata3;
                gotErr = err3;
                check({tag, " stallResp"}, 32'(stall3), 32'd0);
                break;
            end
            if (stall3) nStall++;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " stallCycles"}, 32'(nStall), 32'd2);
        check({tag, " rdata"}, gotData, expData);
        check({tag, " err"}, 32'(gotErr), 32'(expErr));
        cyc();
        #1;
        check({tag, " pulseEnd"}, 32'(respValid3), 32'd0);
        check({tag, " readyAgain"}, 32'(ready3), 32'd1);
        check({tag, " rdataHeld"}, rdata3, expData);
    endtask

    initial begin
        int pulses;
        int respAt;
        logic [31:0] gotData;

        nChecks = 0;
        nFails = 0;
        reset = 1'b0;
        rv3 = 1'b0; rw3 = 1'b0; ra3 = 32'd0; rd3 = 32'd0;
        rv1 = 1'b0; rw1 = 1'b0; ra1 = 32'd0; rd1 = 32'd0;

        // Reset held for two edges, then idle cycles.
        cyc();
        cyc();
        #1;
        check("rst ready", 32'(ready3), 32'd1);
        check("rst respValid", 32'(respValid3), 32'd0);
        check("rst rdata", rdata3, 32'd0);
        check("rst err", 32'(err3), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            check("idle ready", 32'(ready3), 32'd1);
            check("idle respValid", 32'(respValid3), 32'd0);
            check("idle stall", 32'(stall3), 32'd0);
            check("idle rdata", rdata3, 32'd0);
        end

        // Store then load at LATENCY=3, plus top-of-range index 255.
        acc3("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
        acc3("lw10", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
        acc3("sw20", 1'b1, 32'h20, 32'h1111_2222, 32'd0, 1'b0);
        acc3("sw3fc", 1'b1, 32'h3FC, 32'h5A5A_A5A5, 32'd0, 1'b0);

        // Error cases: misaligned store must not touch word 4; index 256 is out of range.
        acc3("swMis", 1'b1, 32'h13, 32'hFFFF_FFFF, 32'd0, 1'b1);
        acc3("lw3fc", 1'b0, 32'h3FC, 32'd0, 32'h5A5A_A5A5, 1'b0);
        acc3("lwOor", 1'b0, 32'h400, 32'd0, 32'd0, 1'b1);
        acc3("lw10b", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // Reset one cycle after accepting a store: no response, store discarded.
        cyc();
        rv3 = 1'b1; rw3 = 1'b1; ra3 = 32'h20; rd3 = 32'hAAAA_5555;
        #1;
        check("midRst accept", 32'(ready3), 32'd1);
        cyc();
        rv3 = 1'b0;
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
        check("midRst ready", 32'(ready3), 32'd1);
        check("midRst stall", 32'(stall3), 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (respValid3) pulses++;
            cyc();
            #1;
        end
        check("midRst pulses", 32'(pulses), 32'd0);
        acc3("lw20", 1'b0, 32'h20, 32'd0, 32'h1111_2222, 1'b0);

        // Request inputs changed during WAIT must be ignored.
        acc3("sw30", 1'b1, 32'h30, 32'hCAFE_F00D, 32'd0, 1'b0);
        acc3("sw34", 1'b1, 32'h34, 32'h0BAD_C0DE, 32'd0, 1'b0);
        cyc();
        rv3 = 1'b1; rw3 = 1'b0; ra3 = 32'h30; rd3 = 32'd0;
        #1;
        check("ign accept", 32'(ready3), 32'd1);
        pulses = 0;
        respAt = 0;
        gotData = 32'hxxxx_xxxx;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i <= 2) begin
                rv3 = 1'b1; rw3 = 1'b1; ra3 = 32'h34; rd3 = 32'h9999_9999;
            end else begin
                rv3 = 1'b0;
            end
            #1;
            if (respValid3) begin
                pulses++;
                respAt = i;
                gotData = rdata3;
            end
        end
        check("ign pulses", 32'(pulses), 32'd1);
        check("ign latency", 32'(respAt), 32'd3);
        check("ign rdata", gotData, 32'hCAFE_F00D);
        acc3("lw34", 1'b0, 32'h34, 32'd0, 32'h0BAD_C0DE, 1'b0);

        // LATENCY=1 instance: back-to-back store and load.
        cyc();
        rv1 = 1'b1; rw1 = 1'b1; ra1 = 32'h4; rd1 = 32'h1234_5678;
        #1;
        check("l1 sw ready", 32'(ready1), 32'd1);
        check("l1 sw stall", 32'(stall1), 32'd1);
        cyc();
        rv1 = 1'b0;
        #1;
        check("l1 sw respValid", 32'(respValid1), 32'd1);
        check("l1 sw readyLow", 32'(ready1), 32'd0);
        check("l1 sw err", 32'(err1), 32'd0);
        check("l1 sw stallResp", 32'(stall1), 32'd0);
        cyc();
        rv1 = 1'b1; rw1 = 1'b0; ra1 = 32'h4; rd1 = 32'd0;
        #1;
        check("l1 lw ready", 32'(ready1), 32'd1);
        check("l1 lw respIdle", 32'(respValid1), 32'd0);
        cyc();
        rv1 = 1'b0;
        #1;
        check("l1 lw respValid", 32'(respValid1), 32'd1);
        check("l1 lw rdata", rdata1, 32'h1234_5678);
        cyc();
        #1;
        check("l1 lw pulseEnd", 32'(respValid1), 32'd0);
        check("l1 lw rdataHeld", rdata1, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
